// File: rtl/patch_diff_accum.sv
// patch_diff_accum: streaming SSD/SAD engine, one pixel pair per cycle,
// one score per PATCH_LEN-pixel patch on a valid/ready result port.
//
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   mode_in                  0 = SSD, 1 = SAD (taken with first pixel)
//   abort_in                 drop current patch and in-flight pixels
//   valid_in/ready_out       pixel pair handshake
//   a_in, b_in               pixel pair
//   result_valid_out/
//   result_ready_in          score handshake
//   result_out               patch score
//   best_valid_out           group best valid (with last group result)
//   best_score_out           minimum score in group
//   best_idx_out             candidate index of minimum
//
// Optional feature macro: BEST_TRACK_EN (best-of-NUM_CAND tracking).
// Without it the best_* outputs are tied to 0.

module patch_diff_accum #(
    parameter int PIX_W     = 8,
    parameter int PATCH_LEN = 64,
    parameter int NUM_CAND  = 16,
    localparam int ACC_W = 2 * PIX_W + $clog2(PATCH_LEN),
    localparam int IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             mode_in,
    input  logic             abort_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [PIX_W-1:0] a_in,
    input  logic [PIX_W-1:0] b_in,
    output logic             result_valid_out,
    input  logic             result_ready_in,
    output logic [ACC_W-1:0] result_out,
    output logic             best_valid_out,
    output logic [ACC_W-1:0] best_score_out,
    output logic [IDX_W-1:0] best_idx_out
);

    localparam int CNT_W = $clog2(PATCH_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATCH_LEN - 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mode_q;
    logic             mode_d;

    logic             accept;
    logic             pix_mode;
    logic             pix_first;
    logic             pix_last;
    logic [PIX_W-1:0] diff;

    // Stage 1: absolute difference plus patch tags
    logic             s1_valid;
    logic [PIX_W-1:0] s1_d;
    logic             s1_mode;
    logic             s1_first;
    logic             s1_last;

    // Stage 2: per-pixel term
    logic               s2_valid;
    logic [ACC_W-1:0]   s2_term;
    logic               s2_first;
    logic               s2_last;
    logic [2*PIX_W-1:0] d_ext;
    logic [2*PIX_W-1:0] sq;
    logic [ACC_W-1:0]   term;

    // Stage 3: accumulator and result
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum;
    logic             load;

    // A held, unconsumed result stalls the pixel input.
    assign ready_out = !(result_valid_out && !result_ready_in);
    assign accept    = valid_in && ready_out && !abort_in;

    assign diff = (a_in > b_in) ? (a_in - b_in) : (b_in - a_in);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        pix_mode  = mode_q;
        pix_first = 1'b0;
        pix_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                pix_mode  = mode_in;
                pix_first = 1'b1;
                if (accept) begin
                    state_d = ACCUM;
                    cnt_d   = CNT_W'(1);
                    mode_d  = mode_in;
                end
            end
            ACCUM: begin
                pix_last = (cnt_q == LAST_CNT);
                if (accept) begin
                    if (pix_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
        if (abort_in) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_d     <= '0;
            s1_mode  <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_d     <= diff;
                s1_mode  <= pix_mode;
                s1_first <= pix_first;
                s1_last  <= pix_last;
            end
        end
    end

    assign d_ext = {{PIX_W{1'b0}}, s1_d};
    assign sq    = d_ext * d_ext;
    assign term  = s1_mode
                 ? {{(ACC_W-PIX_W){1'b0}}, s1_d}
                 : {{(ACC_W-2*PIX_W){1'b0}}, sq};

    always_ff @(posedge clk_in) begin
        if (rst_in || abort_in) begin
            s2_valid <= 1'b0;
            s2_term  <= '0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_term  <= term;
                s2_first <= s1_first;
                s2_last  <= s1_last;
            end
        end
    end

    assign sum  = s2_first ? s2_term : (acc_q + s2_term);
    assign load = s2_valid && s2_last && !abort_in;

    always_ff @(posedge clk_in) begin
        if (rst_in || abort_in) begin
            acc_q <= '0;
        end else if (s2_valid) begin
            acc_q <= s2_last ? '0 : sum;
        end
    end

    // A fresh score takes priority over a same-cycle handshake clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            result_valid_out <= 1'b0;
            result_out       <= '0;
        end else if (load) begin
            result_valid_out <= 1'b1;
            result_out       <= sum;
        end else if (result_ready_in) begin
            result_valid_out <= 1'b0;
        end
    end

`ifdef BEST_TRACK_EN
    logic [IDX_W-1:0] cand_q;
    logic [ACC_W-1:0] best_q;
    logic [IDX_W-1:0] bidx_q;
    logic             take;
    logic             cand_last;
    logic [ACC_W-1:0] nb_score;
    logic [IDX_W-1:0] nb_idx;

    // Strict compare: ties keep the earlier candidate.
    always_comb begin
        take      = (cand_q == '0) || (sum < best_q);
        nb_score  = take ? sum : best_q;
        nb_idx    = take ? cand_q : bidx_q;
        cand_last = (cand_q == IDX_W'(NUM_CAND - 1));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cand_q         <= '0;
            best_q         <= '0;
            bidx_q         <= '0;
            best_valid_out <= 1'b0;
            best_score_out <= '0;
            best_idx_out   <= '0;
        end else begin
            if (abort_in) begin
                cand_q <= '0;
                best_q <= '0;
                bidx_q <= '0;
            end else if (load) begin
                best_q <= nb_score;
                bidx_q <= nb_idx;
                cand_q <= cand_last ? '0 : cand_q + IDX_W'(1);
            end
            if (load) begin
                best_valid_out <= cand_last;
                if (cand_last) begin
                    best_score_out <= nb_score;
                    best_idx_out   <= nb_idx;
                end
            end else if (result_ready_in) begin
                best_valid_out <= 1'b0;
            end
        end
    end
`else
    assign best_valid_out = 1'b0;
    assign best_score_out = '0;
    assign best_idx_out   = '0;
`endif

endmodule

// File: tb/tb_patch_diff_accum.sv
// tb_patch_diff_accum: directed vectors for patch_diff_accum,
// PATCH_LEN=4/NUM_CAND=4 instance plus a default 64-pixel instance.

module tb_patch_diff_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       abort;
    logic       valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       rr;

    logic        rdy4, rv4, bv4;
    logic [17:0] res4, bs4;
    logic [1:0]  bi4;

    logic        rdy64, rv64, bv64;
    logic [21:0] res64, bs64;
    logic [3:0]  bi64;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned q_res[$];
    int unsigned q_bv[$];
    int unsigned q_bs[$];
    int unsigned q_bi[$];
    int unsigned q64[$];

    always #5 clk = ~clk;

    patch_diff_accum #(
        .PIX_W(8), .PATCH_LEN(4), .NUM_CAND(4)
    ) u4 (
        .clk_in(clk), .rst_in(rst), .mode_in(mode),
        .abort_in(abort), .valid_in(valid), .ready_out(rdy4),
        .a_in(a), .b_in(b),
        .result_valid_out(rv4), .result_ready_in(rr),
        .result_out(res4), .best_valid_out(bv4),
        .best_score_out(bs4), .best_idx_out(bi4)
    );

    patch_diff_accum u64 (
        .clk_in(clk), .rst_in(rst), .mode_in(mode),
        .abort_in(abort), .valid_in(valid), .ready_out(rdy64),
        .a_in(a), .b_in(b),
        .result_valid_out(rv64), .result_ready_in(rr),
        .result_out(res64), .best_valid_out(bv64),
        .best_score_out(bs64), .best_idx_out(bi64)
    );

    // Record every score that is handshaken on the next edge.
    always @(negedge clk) begin
        if (!rst && rv4 && rr) begin
            q_res.push_back(32'(res4));
            q_bv.push_back(32'(bv4));
            q_bs.push_back(32'(bs4));
            q_bi.push_back(32'(bi4));
        end
        if (!rst && rv64 && rr) q64.push_back(32'(res64));
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_q();
        q_res.delete();
        q_bv.delete();
        q_bs.delete();
        q_bi.delete();
        q64.delete();
    endtask

    task automatic send(input logic [7:0] pa,
                        input logic [7:0] pb,
                        input logic pm);
        logic ok;
        ok    = 1'b0;
        valid = 1'b1;
        a     = pa;
        b     = pb;
        mode  = pm;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = rdy4;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        mode  = 1'b0;
        abort = 1'b0;
        valid = 1'b0;
        a     = '0;
        b     = '0;
        rr    = 1'b1;
        do_reset();

        // reset state
        check("rst_ready", 32'(rdy4), 32'd1);
        check("rst_rvalid", 32'(rv4), 32'd0);
        check("rst_result", 32'(res4), 32'd0);
        check("rst_bvalid", 32'(bv4), 32'd0);
        check("rst_bscore", 32'(bs4), 32'd0);
        check("rst_bidx", 32'(bi4), 32'd0);

        // SSD with latency check
        clear_q();
        send(8'd10, 8'd7, 1'b0);
        send(8'd3, 8'd5, 1'b0);
        send(8'd0, 8'd255, 1'b0);
        send(8'd100, 8'd100, 1'b0);
        check("ssd_lat_t1", 32'(rv4), 32'd0);
        idle(1);
        check("ssd_lat_t2", 32'(rv4), 32'd0);
        idle(1);
        check("ssd_lat_t3", 32'(rv4), 32'd1);
        check("ssd_value", 32'(res4), 32'd65038);
        idle(3);
        check("ssd_count", 32'(q_res.size()), 32'd1);
        check("ssd_rvalid_clr", 32'(rv4), 32'd0);

        // SAD, then SAD with mode toggled mid-patch
        clear_q();
        send(8'd10, 8'd7, 1'b1);
        send(8'd3, 8'd5, 1'b1);
        send(8'd0, 8'd255, 1'b1);
        send(8'd100, 8'd100, 1'b1);
        send(8'd10, 8'd7, 1'b1);
        send(8'd3, 8'd5, 1'b0);
        send(8'd0, 8'd255, 1'b0);
        send(8'd100, 8'd100, 1'b1);
        idle(5);
        check("sad_count", 32'(q_res.size()), 32'd2);
        check("sad_value", q_res[0], 32'd260);
        check("sad_toggle", q_res[1], 32'd260);

        // backpressure over two back-to-back patches
        clear_q();
        rr = 1'b0;
        fork
            begin
                send(8'd10, 8'd7, 1'b0);
                send(8'd3, 8'd5, 1'b0);
                send(8'd0, 8'd255, 1'b0);
                send(8'd100, 8'd100, 1'b0);
                for (int i = 0; i < 4; i++)
                    send(8'd2, 8'd5, 1'b0);
            end
            begin
                idle(8);
                check("bp_ready_low", 32'(rdy4), 32'd0);
                check("bp_held_valid", 32'(rv4), 32'd1);
                check("bp_held_a", 32'(res4), 32'd65038);
                idle(2);
                check("bp_held_b", 32'(res4), 32'd65038);
                rr = 1'b1;
            end
        join
        idle(6);
        check("bp_count", 32'(q_res.size()), 32'd2);
        check("bp_first", q_res[0], 32'd65038);
        check("bp_second", q_res[1], 32'd36);

        // abort after two pixels, pixel in abort cycle dropped
        clear_q();
        send(8'd5, 8'd0, 1'b0);
        send(8'd5, 8'd0, 1'b0);
        abort = 1'b1;
        valid = 1'b1;
        a     = 8'd9;
        b     = 8'd0;
        idle(1);
        abort = 1'b0;
        valid = 1'b0;
        idle(6);
        check("abort_no_result", 32'(q_res.size()), 32'd0);
        for (int i = 0; i < 4; i++)
            send(8'd1, 8'd0, 1'b0);
        idle(6);
        check("abort_count", 32'(q_res.size()), 32'd1);
        check("abort_value", q_res[0], 32'd4);

        // best-of-group: SAD scores 50,20,20,70
        do_reset();
        clear_q();
        send(8'd50, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) send(8'd7, 8'd7, 1'b1);
        send(8'd0, 8'd20, 1'b1);
        for (int i = 0; i < 3; i++) send(8'd7, 8'd7, 1'b1);
        send(8'd10, 8'd0, 1'b1);
        send(8'd0, 8'd10, 1'b1);
        send(8'd3, 8'd3, 1'b1);
        send(8'd3, 8'd3, 1'b1);
        send(8'd70, 8'd0, 1'b1);
        for (int i = 0; i < 3; i++) send(8'd1, 8'd1, 1'b1);
        idle(6);
        check("grp_count", 32'(q_res.size()), 32'd4);
        check("grp_s0", q_res[0], 32'd50);
        check("grp_s1", q_res[1], 32'd20);
        check("grp_s2", q_res[2], 32'd20);
        check("grp_s3", q_res[3], 32'd70);
        check("grp_bv0", q_bv[0], 32'd0);
`ifdef BEST_TRACK_EN
        check("grp_bv3", q_bv[3], 32'd1);
        check("grp_best", q_bs[3], 32'd20);
        check("grp_idx", q_bi[3], 32'd1);
`else
        check("grp_bv3", q_bv[3], 32'd0);
        check("grp_best", q_bs[3], 32'd0);
        check("grp_idx", q_bi[3], 32'd0);
`endif

        // full-size patch at maximum difference
        do_reset();
        clear_q();
        for (int i = 0; i < 64; i++)
            send(8'd255, 8'd0, 1'b0);
        idle(8);
        check("big_count", 32'(q64.size()), 32'd1);
        check("big_value", q64[0], 32'd4161600);
        check("big_bvalid", 32'(bv64), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
